// File: rtl/display_pkg.sv
`default_nettype none
// display_pkg: shared widths, iteration bound and state encoding for the BCD display path (rev 1.0).
package display_pkg;

  localparam int DATA_W     = 32;
  localparam int NUM_DIGITS = 10;
  localparam int ITER_LAST  = DATA_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } display_state_t;

  // True when NUM_DIGITS decimal digits can hold any magnitude of a signed w-bit word.
  function automatic bit digits_ok(input int nd, input int w);
    longint unsigned p;
    p = 64'd1;
    if (nd >= 19) return 1'b1;
    for (int i = 0; i < nd; i++) p = p * 64'd10;
    return p > (64'd1 << (w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_dabble_step.sv
`default_nettype none
// bcd_dabble_step: one double-dabble iteration (add-3 on nibbles >= 5, then shift left by one) (rev 1.0).
module bcd_dabble_step #(
  parameter int NUM_DIGITS = 10
) (
  input  logic [4*NUM_DIGITS-1:0] acc_in,
  input  logic                    shift_in,
  output logic [4*NUM_DIGITS-1:0] acc_out
);

  logic [NUM_DIGITS-1:0] ge5;

  // For a valid BCD nibble the bit carried into the next digit after the
  // correction is exactly ge5, so only the low three corrected bits are formed.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign ge5[i] = (acc_in[4*i +: 4] >= 4'd5);
    assign acc_out[4*i+1 +: 3] = acc_in[4*i +: 3] + {1'b0, ge5[i], ge5[i]};
    if (i == 0) begin : g_lsb
      assign acc_out[0] = shift_in;
    end else begin : g_upper
      assign acc_out[4*i] = ge5[i-1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/display_bcd_controller.sv
`default_nettype none
// display_bcd_controller: signed 32-bit write -> ten committed BCD digits via shared double-dabble (rev 1.0).
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_bcd_controller #(
  parameter int DATA_W     = display_pkg::DATA_W,
  parameter int NUM_DIGITS = display_pkg::NUM_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    neg,
  output logic [NUM_DIGITS-1:0]   blank
);

  import display_pkg::*;

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W) + 1;

  if (DATA_W != 32) begin : g_bad_width
    $error("display_bcd_controller: DATA_W must be 32");
  end
  if (!digits_ok(NUM_DIGITS, DATA_W)) begin : g_bad_digits
    $error("display_bcd_controller: NUM_DIGITS too small for DATA_W");
  end

  display_state_t        state, next_state;
  logic [DATA_W-1:0]     shift_reg, pending_data, load_val, load_mag;
  logic [BCD_W-1:0]      acc, acc_step;
  logic [CNT_W-1:0]      count;
  logic                  sign_r, mag_nz, pending_valid, conv_last, start_load;
  logic [NUM_DIGITS-1:0] blank_next;

  bcd_dabble_step #(.NUM_DIGITS(NUM_DIGITS)) u_step (
    .acc_in   (acc),
    .shift_in (shift_reg[DATA_W-1]),
    .acc_out  (acc_step)
  );

  // The counter runs one past the last iteration so the commit edge sees the final accumulator.
  assign conv_last  = (count == CNT_W'(ITER_LAST + 1));
  assign load_val   = (state == DONE && !wr_en) ? pending_data : wr_data;
  assign load_mag   = load_val[DATA_W-1] ? (~load_val + 1'b1) : load_val;
  assign start_load = (state == IDLE && wr_en) || (state == DONE && (wr_en || pending_valid));

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank_next = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero && (acc[4*i +: 4] == 4'd0);
      blank_next[i] = upper_zero;
    end
  end
`else
  assign blank_next = '0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (wr_en) next_state = CONV;
      CONV:    if (conv_last) next_state = DONE;
      DONE:    next_state = (wr_en || pending_valid) ? CONV : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      bcd           <= '0;
      neg           <= 1'b0;
      blank         <= '0;
      acc           <= '0;
      shift_reg     <= '0;
      count         <= '0;
      sign_r        <= 1'b0;
      mag_nz        <= 1'b0;
      pending_valid <= 1'b0;
      pending_data  <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (next_state == DONE);

      if (start_load) begin
        shift_reg     <= load_mag;
        sign_r        <= load_val[DATA_W-1];
        mag_nz        <= |load_mag;
        acc           <= '0;
        count         <= '0;
        pending_valid <= 1'b0;
      end else if (state == CONV) begin
        if (!conv_last) begin
          acc       <= acc_step;
          shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
          count     <= count + 1'b1;
        end else begin
          bcd   <= acc;
          neg   <= sign_r && mag_nz;
          blank <= blank_next;
        end
        if (wr_en) begin
          pending_valid <= 1'b1;
          pending_data  <= wr_data;
        end
      end
    end
  end

endmodule
`default_nettype wire
